serial_alu_ctrl: RTL

SERIAL_ALU_CTRL -- requirements
Module: serial_alu_ctrl

---
 rtl/serial_alu_ctrl.sv | 80 ++++++++
 1 files changed

// File: rtl/serial_alu_ctrl.sv
// serial_alu_ctrl: sequences two 8-bit operands LSB-first through an external one-bit ALU and assembles the result
module serial_alu_ctrl (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic [7:0] a,
    input  logic [7:0] b,
    input  logic [1:0] op,
    input  logic       cin,
    input  logic       alu_y,
    input  logic       alu_z,
    output logic       alu_a,
    output logic       alu_b,
    output logic       alu_cin,
    output logic       alu_c1,
    output logic       alu_c0,
    output logic [7:0] result,
    output logic       carry_out,
    output logic       busy,
    output logic       done
);
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
    state_t     state;
    logic [7:0] a_sr, b_sr;
    logic [1:0] op_r;
    logic       carry;
    logic [2:0] cnt;
    logic       sel_bit, new_carry;
    assign alu_a     = a_sr[0];
    assign alu_b     = b_sr[0];
    assign alu_cin   = carry;
    assign alu_c1    = op_r[1];
    assign alu_c0    = op_r[0];
    assign sel_bit   = op_r == 2'b11 ? alu_z : alu_y;
    assign new_carry = op_r == 2'b00 ? alu_z : 1'b0;
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            a_sr      <= '0;
            b_sr      <= '0;
            op_r      <= '0;
            carry     <= 1'b0;
            cnt       <= '0;
            result    <= '0;
            carry_out <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            case (state)
                IDLE: if (start) begin
                    a_sr  <= a;
                    b_sr  <= b;
                    op_r  <= op;
                    carry <= cin;
                    cnt   <= '0;
                    busy  <= 1'b1;
                    state <= RUN;
                end
                RUN: begin
                    a_sr   <= a_sr >> 1;
                    b_sr   <= b_sr >> 1;
                    result <= {sel_bit, result[7:1]};
                    carry  <= new_carry;
                    cnt    <= cnt + 3'd1;
                    if (cnt == 3'd7) begin
                        carry_out <= new_carry;
                        busy      <= 1'b0;
                        done      <= 1'b1;
                        state     <= DONE;
                    end
                end
                DONE: begin
                    done  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
